// File: rtl/clock_pkg.sv
// Shared types, limits and helpers for the BCD time-of-day path.
// Time is kept as packed BCD byte pairs: {tens, units}.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } time_bcd_t;

  localparam logic [6:0] SEC_MAX = 7'd59;
  localparam logic [6:0] MIN_MAX = 7'd59;
  localparam logic [6:0] HR_MAX  = 7'd23;

  function automatic logic [6:0] bcd2bin(
    input logic [7:0] v
  );
    return ({3'b000, v[7:4]} * 7'd10)
         + {3'b000, v[3:0]};
  endfunction

  // Both nibbles decimal and value within max.
  function automatic logic bcd_ok(
    input logic [7:0] v,
    input logic [6:0] max
  );
    return (v[7:4] <= 4'd9)
        && (v[3:0] <= 4'd9)
        && (bcd2bin(v) <= max);
  endfunction

  // Seconds are don't-care for alarm loads.
  function automatic logic load_ok(
    input time_bcd_t t,
    input logic      alarm
  );
    return bcd_ok(t.hh, HR_MAX)
        && bcd_ok(t.mm, MIN_MAX)
        && (alarm || bcd_ok(t.ss, SEC_MAX));
  endfunction

  // 24h hour to 12h hour: 00->12, 13..23->01..11.
  function automatic logic [7:0] hr12(
    input logic [7:0] hh
  );
    logic [6:0] b;
    logic [6:0] r;
    logic [6:0] u;
    b = bcd2bin(hh);
    if (b == 7'd0) begin
      r = 7'd12;
    end else if (b > 7'd12) begin
      r = b - 7'd12;
    end else begin
      r = b;
    end
    if (r >= 7'd10) begin
      u = r - 7'd10;
      return {4'd1, u[3:0]};
    end
    return {4'd0, r[3:0]};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, modulus MOD (<= 100).
// Load beats increment; carry is a wrap on increment.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] val_q,
  output logic [7:0] val_d,
  output logic       carry
);

  localparam bcd_t MAX_T = bcd_t'((MOD - 1) / 10);
  localparam bcd_t MAX_U = bcd_t'((MOD - 1) % 10);

  logic at_max;
  bcd_t tens;
  bcd_t units;

  assign tens   = val_q[7:4];
  assign units  = val_q[3:0];
  assign at_max = (val_q == {MAX_T, MAX_U});
  assign carry  = inc && !ld && at_max;

  // Next value: load, wrap, decade carry or unit step.
  always_comb begin
    val_d = val_q;
    if (ld) begin
      val_d = ld_val;
    end else if (inc) begin
      if (at_max) begin
        val_d = 8'h00;
      end else if (units == 4'd9) begin
        val_d = {tens + 4'd1, 4'd0};
      end else begin
        val_d = {tens, units + 4'd1};
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// BCD HH:MM:SS time keeper with prescaler, loading and 12/24h view.
// Alarm logic is built only when BCD_TIME_KEEPER_ALARM_EN is defined.
module bcd_time_keeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DIV_W    = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode12,
  input  logic       set_valid,
  input  logic       set_alarm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       set_err,
  output logic       sec_tick,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       pm,
  input  logic       alarm_ack,
  output logic       alarm_ring
);

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  time_bcd_t set_t;
  time_bcd_t time_q;
  time_bcd_t time_d;
  time_bcd_t disp_q;
  time_bcd_t disp_d;

  logic tick;
  logic req_ok;
  logic ld_time;
  logic ss_carry;
  logic mm_carry;
  logic hh_carry_unused;

  logic pm_q;
  logic pm_d;
  logic sec_tick_q;
  logic sec_tick_d;
  logic set_err_q;
  logic set_err_d;

  assign set_t   = {set_hh, set_mm, set_ss};
  assign req_ok  = load_ok(set_t, set_alarm);
  assign ld_time = set_valid && req_ok && !set_alarm;
  assign tick    = run && (div_cnt_q == DIV_LAST);

  // Prescaler: wraps on tick, clears on time load.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (ld_time || tick) begin
      div_cnt_d = '0;
    end else if (run) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  bcd_mod_counter #(.MOD(60)) u_ss (
    .clk    (clk),
    .rst    (rst),
    .inc    (tick && !ld_time),
    .ld     (ld_time),
    .ld_val (set_ss),
    .val_q  (time_q.ss),
    .val_d  (time_d.ss),
    .carry  (ss_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_mm (
    .clk    (clk),
    .rst    (rst),
    .inc    (ss_carry),
    .ld     (ld_time),
    .ld_val (set_mm),
    .val_q  (time_q.mm),
    .val_d  (time_d.mm),
    .carry  (mm_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_hh (
    .clk    (clk),
    .rst    (rst),
    .inc    (mm_carry),
    .ld     (ld_time),
    .ld_val (set_hh),
    .val_q  (time_q.hh),
    .val_d  (time_d.hh),
    .carry  (hh_carry_unused)
  );

  // Display built from next time so it lands with the update.
  always_comb begin
    disp_d     = time_d;
    pm_d       = (time_d.hh > 8'h11);
    sec_tick_d = tick;
    set_err_d  = set_valid && !req_ok;
    if (mode12) begin
      disp_d.hh = hr12(time_d.hh);
    end
  end

  // Prescaler and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      disp_q     <= '0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      disp_q     <= disp_d;
      pm_q       <= pm_d;
      sec_tick_q <= sec_tick_d;
      set_err_q  <= set_err_d;
    end
  end

  assign h1       = disp_q.hh[7:4];
  assign h0       = disp_q.hh[3:0];
  assign m1       = disp_q.mm[7:4];
  assign m0       = disp_q.mm[3:0];
  assign s1       = disp_q.ss[7:4];
  assign s0       = disp_q.ss[3:0];
  assign pm       = pm_q;
  assign sec_tick = sec_tick_q;
  assign set_err  = set_err_q;

`ifdef BCD_TIME_KEEPER_ALARM_EN

  logic [15:0] alarm_q;
  logic [15:0] alarm_d;
  logic        ring_q;
  logic        ring_d;
  logic        ld_alarm;
  logic        match;

  assign ld_alarm = set_valid && req_ok && set_alarm;
  assign match    = tick && !ld_time
                 && (time_d == {alarm_q, 8'h00});

  // Alarm register load; a new match beats ack and minute change.
  always_comb begin
    alarm_d = alarm_q;
    ring_d  = ring_q;
    if (ld_alarm) begin
      alarm_d = {set_hh, set_mm};
    end
    if (match) begin
      ring_d = 1'b1;
    end else if (alarm_ack
              || (time_d.mm != time_q.mm)) begin
      ring_d = 1'b0;
    end
  end

  // Alarm state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 16'h0000;
      ring_q  <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
      ring_q  <= ring_d;
    end
  end

  assign alarm_ring = ring_q;

`else

  logic unused_alarm_ack;

  assign unused_alarm_ack = alarm_ack;
  assign alarm_ring       = 1'b0;

`endif

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed bench for bcd_time_keeper with TICK_DIV = 4.
// Load table plus hand sequences for carries, hold, alarm, reset.
module tb_bcd_time_keeper;

`ifdef BCD_TIME_KEEPER_ALARM_EN
  localparam logic ALM = 1'b1;
`else
  localparam logic ALM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       mode12;
  logic       set_valid;
  logic       set_alarm;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic       set_err;
  logic       sec_tick;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic       pm;
  logic       alarm_ack;
  logic       alarm_ring;

  int total = 0;
  int bad   = 0;

  bcd_time_keeper #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mode12     (mode12),
    .set_valid  (set_valid),
    .set_alarm  (set_alarm),
    .set_hh     (set_hh),
    .set_mm     (set_mm),
    .set_ss     (set_ss),
    .set_err    (set_err),
    .sec_tick   (sec_tick),
    .h1         (h1),
    .h0         (h0),
    .m1         (m1),
    .m0         (m0),
    .s1         (s1),
    .s0         (s0),
    .pm         (pm),
    .alarm_ack  (alarm_ack),
    .alarm_ring (alarm_ring)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       m12;
    logic [7:0] eh;
    logic [7:0] em;
    logic [7:0] es;
    logic       epm;
    logic       eerr;
  } vec_t;

  vec_t v[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, got, exp);
    end
  endtask

  task automatic chk_time(
    input string      name,
    input logic [7:0] eh,
    input logic [7:0] em,
    input logic [7:0] es
  );
    chk({name, ".hh"}, {24'h0, h1, h0}, {24'h0, eh});
    chk({name, ".mm"}, {24'h0, m1, m0}, {24'h0, em});
    chk({name, ".ss"}, {24'h0, s1, s0}, {24'h0, es});
  endtask

  task automatic load(
    input logic [7:0] hh,
    input logic [7:0] mm,
    input logic [7:0] ss,
    input logic       alm
  );
    set_hh    = hh;
    set_mm    = mm;
    set_ss    = ss;
    set_alarm = alm;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    set_alarm = 1'b0;
  endtask

  initial begin
    v[0] = '{8'h23, 8'h59, 8'h58, 1'b0,
             8'h23, 8'h59, 8'h58, 1'b1, 1'b0};
    v[1] = '{8'h00, 8'h30, 8'h00, 1'b1,
             8'h12, 8'h30, 8'h00, 1'b0, 1'b0};
    v[2] = '{8'h13, 8'h05, 8'h00, 1'b1,
             8'h01, 8'h05, 8'h00, 1'b1, 1'b0};
    v[3] = '{8'h12, 8'h00, 8'h00, 1'b1,
             8'h12, 8'h00, 8'h00, 1'b1, 1'b0};
    v[4] = '{8'h23, 8'h00, 8'h00, 1'b1,
             8'h11, 8'h00, 8'h00, 1'b1, 1'b0};
    v[5] = '{8'h09, 8'h59, 8'h59, 1'b0,
             8'h09, 8'h59, 8'h59, 1'b0, 1'b0};
    v[6] = '{8'h24, 8'h00, 8'h00, 1'b0,
             8'h09, 8'h59, 8'h59, 1'b0, 1'b1};
    v[7] = '{8'h10, 8'h5A, 8'h00, 1'b0,
             8'h09, 8'h59, 8'h59, 1'b0, 1'b1};
    v[8] = '{8'h10, 8'h00, 8'h60, 1'b0,
             8'h09, 8'h59, 8'h59, 1'b0, 1'b1};
    v[9] = '{8'h0A, 8'h00, 8'h00, 1'b0,
             8'h09, 8'h59, 8'h59, 1'b0, 1'b1};

    rst       = 1'b0;
    run       = 1'b0;
    mode12    = 1'b0;
    set_valid = 1'b0;
    set_alarm = 1'b0;
    set_hh    = 8'h00;
    set_mm    = 8'h00;
    set_ss    = 8'h00;
    alarm_ack = 1'b0;

    #2 rst = 1'b1;
    steps(2);
    chk_time("rst", 8'h00, 8'h00, 8'h00);
    chk("rst.pm", {31'h0, pm}, 32'h0);
    chk("rst.tick", {31'h0, sec_tick}, 32'h0);
    chk("rst.err", {31'h0, set_err}, 32'h0);
    chk("rst.ring", {31'h0, alarm_ring}, 32'h0);

    // Free run from release: tick every 4th edge.
    rst = 1'b0;
    run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("run.tick%0d", k),
          {31'h0, sec_tick},
          {31'h0, (k % 4) == 0});
      if ((k % 4) == 0) begin
        chk($sformatf("run.ss%0d", k),
            {28'h0, s0}, 32'(k / 4));
      end
    end

    // Hold mid-second, then resume with 2 left.
    steps(2);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold.ss", {28'h0, s0}, 32'd3);
      chk("hold.tick", {31'h0, sec_tick}, 32'h0);
    end
    run = 1'b1;
    step();
    chk("resume1.tick", {31'h0, sec_tick}, 32'h0);
    chk("resume1.ss", {28'h0, s0}, 32'd3);
    step();
    chk("resume2.tick", {31'h0, sec_tick}, 32'h1);
    chk("resume2.ss", {28'h0, s0}, 32'd4);

    // Load table with time held.
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode12 = v[i].m12;
      load(v[i].hh, v[i].mm, v[i].ss, 1'b0);
      chk_time($sformatf("vec%0d", i),
               v[i].eh, v[i].em, v[i].es);
      chk($sformatf("vec%0d.pm", i),
          {31'h0, pm}, {31'h0, v[i].epm});
      chk($sformatf("vec%0d.err", i),
          {31'h0, set_err}, {31'h0, v[i].eerr});
      step();
      chk($sformatf("vec%0d.err_end", i),
          {31'h0, set_err}, 32'h0);
    end

    // Day rollover and hour-digit carries.
    mode12 = 1'b0;
    run    = 1'b1;
    load(8'h23, 8'h59, 8'h58, 1'b0);
    steps(4);
    chk_time("roll1", 8'h23, 8'h59, 8'h59);
    chk("roll1.pm", {31'h0, pm}, 32'h1);
    steps(4);
    chk_time("roll2", 8'h00, 8'h00, 8'h00);
    chk("roll2.pm", {31'h0, pm}, 32'h0);
    chk("roll2.tick", {31'h0, sec_tick}, 32'h1);
    load(8'h09, 8'h59, 8'h59, 1'b0);
    steps(4);
    chk_time("c09", 8'h10, 8'h00, 8'h00);
    load(8'h19, 8'h59, 8'h59, 1'b0);
    steps(4);
    chk_time("c19", 8'h20, 8'h00, 8'h00);

    // Load on the tick cycle wins; tick discarded.
    steps(3);
    load(8'h05, 8'h06, 8'h07, 1'b0);
    chk_time("ldtick", 8'h05, 8'h06, 8'h07);
    chk("ldtick.tick", {31'h0, sec_tick}, 32'h1);
    step();
    chk_time("ldtick1", 8'h05, 8'h06, 8'h07);
    chk("ldtick1.tick", {31'h0, sec_tick}, 32'h0);
    steps(3);
    chk_time("ldtick4", 8'h05, 8'h06, 8'h08);

    // Alarm load leaves time alone, ss ignored.
    run = 1'b0;
    load(8'h07, 8'h00, 8'hFF, 1'b1);
    chk("alm.err", {31'h0, set_err}, 32'h0);
    chk_time("alm.keep", 8'h05, 8'h06, 8'h08);

    run = 1'b1;
    load(8'h06, 8'h59, 8'h59, 1'b0);
    steps(4);
    chk_time("alm.hit", 8'h07, 8'h00, 8'h00);
    chk("alm.ring", {31'h0, alarm_ring}, {31'h0, ALM});
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("alm.ack", {31'h0, alarm_ring}, 32'h0);

    load(8'h06, 8'h59, 8'h59, 1'b0);
    steps(4);
    chk("alm.ring2", {31'h0, alarm_ring}, {31'h0, ALM});
    steps(4 * 59);
    chk_time("alm.59", 8'h07, 8'h00, 8'h59);
    chk("alm.hold", {31'h0, alarm_ring}, {31'h0, ALM});
    steps(4);
    chk_time("alm.min", 8'h07, 8'h01, 8'h00);
    chk("alm.selfclr", {31'h0, alarm_ring}, 32'h0);

    // Asynchronous reset mid-count, 12h view after release.
    steps(2);
    #2 rst = 1'b1;
    #1;
    chk_time("arst", 8'h00, 8'h00, 8'h00);
    chk("arst.pm", {31'h0, pm}, 32'h0);
    step();
    mode12 = 1'b1;
    rst    = 1'b0;
    step();
    chk_time("rel12", 8'h12, 8'h00, 8'h00);
    chk("rel12.tick", {31'h0, sec_tick}, 32'h0);
    steps(2);
    chk("rel12.tick3", {31'h0, sec_tick}, 32'h0);
    step();
    chk("rel12.tick4", {31'h0, sec_tick}, 32'h1);
    chk_time("rel12.s1", 8'h12, 8'h00, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
